// File: rtl/register_file_bist_ctrl.sv
// March C- BIST initiator for the register-file test port, with first-failure diagnostics.
// Define BIST_CHECKERBOARD_EN to append a second pass using a checkerboard background.
module register_file_bist_ctrl #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  fail_o,
    output logic [CNT_WIDTH-1:0]  fail_cnt_o,
    output logic [ADDR_WIDTH-1:0] fail_addr_o,
    output logic [DATA_WIDTH-1:0] fail_data_o,
    output logic                  BIST,
    output logic                  CSN_T,
    output logic                  WEN_T,
    output logic [ADDR_WIDTH-1:0] A_T,
    output logic [DATA_WIDTH-1:0] D_T,
    input  logic [DATA_WIDTH-1:0] Q_T
);

    typedef enum logic [3:0] {
        S_IDLE, S_M0, S_M1, S_M2, S_M3, S_M4, S_M5, S_DRAIN, S_DONE
    } state_t;

    // down: descending walk; rd/wr: element operations; rb1/wb1: read/write use B1
    typedef struct packed {
        logic down;
        logic rd;
        logic wr;
        logic rb1;
        logic wb1;
    } elem_t;

    function automatic elem_t elem(input state_t s);
        case (s)
            S_M0:    return '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
            S_M1:    return '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
            S_M2:    return '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
            S_M3:    return '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
            S_M4:    return '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
            S_M5:    return '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
            default: return '0;
        endcase
    endfunction

`ifdef BIST_CHECKERBOARD_EN
    function automatic logic [DATA_WIDTH-1:0] cb_bg(input logic a0);
        logic [DATA_WIDTH-1:0] b;
        for (int unsigned i = 0; i < DATA_WIDTH; i++) b[i] = (i[0] == a0);
        return b;
    endfunction

    logic r_pass;
    logic w_npass;
`endif

    state_t                r_state;
    logic                  r_busy;
    logic                  r_pend;
    logic [ADDR_WIDTH-1:0] r_pend_addr;
    logic [DATA_WIDTH-1:0] r_pend_exp;

    elem_t                 w_cur;
    elem_t                 w_nxt_el;
    state_t                w_nstate;
    logic                  w_last;
    logic                  w_nwen;
    logic                  w_nb1;
    logic                  w_ncmd;
    logic [ADDR_WIDTH-1:0] w_naddr;
    logic [DATA_WIDTH-1:0] w_ndata;

    assign busy_o = r_busy;
    assign BIST   = r_busy;

    // Next command from the current one; the command registers double as the march cursor.
    always_comb begin
        w_cur    = elem(r_state);
        w_nxt_el = w_cur;
        w_last   = w_cur.down ? (A_T == '0) : (A_T == '1);
        w_nstate = r_state;
        w_naddr  = A_T;
        w_nwen   = 1'b1;
        w_nb1    = 1'b0;
        w_ncmd   = 1'b0;
`ifdef BIST_CHECKERBOARD_EN
        w_npass  = r_pass;
`endif
        if (w_cur.rd && w_cur.wr && WEN_T) begin
            w_ncmd = 1'b1;
            w_nwen = 1'b0;
            w_nb1  = w_cur.wb1;
        end else begin
            if (!w_last) begin
                w_naddr = w_cur.down ? A_T - 1'b1 : A_T + 1'b1;
            end else begin
                case (r_state)
                    S_M0: w_nstate = S_M1;
                    S_M1: w_nstate = S_M2;
                    S_M2: w_nstate = S_M3;
                    S_M3: w_nstate = S_M4;
                    S_M4: w_nstate = S_M5;
`ifdef BIST_CHECKERBOARD_EN
                    S_M5: begin
                        w_nstate = r_pass ? S_DRAIN : S_M0;
                        w_npass  = 1'b1;
                    end
`else
                    S_M5: w_nstate = S_DRAIN;
`endif
                    default: ;
                endcase
                w_nxt_el = elem(w_nstate);
                w_naddr  = w_nxt_el.down ? '1 : '0;
            end
            w_ncmd = w_nxt_el.rd | w_nxt_el.wr;
            w_nwen = w_nxt_el.rd | ~w_ncmd;
            w_nb1  = w_nxt_el.rd ? w_nxt_el.rb1 : w_nxt_el.wb1;
        end
`ifdef BIST_CHECKERBOARD_EN
        w_ndata = (w_npass ? cb_bg(w_naddr[0]) : '0) ^ {DATA_WIDTH{w_nb1}};
`else
        w_ndata = {DATA_WIDTH{w_nb1}};
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            done_o      <= 1'b0;
            fail_o      <= 1'b0;
            fail_cnt_o  <= '0;
            fail_addr_o <= '0;
            fail_data_o <= '0;
            CSN_T       <= 1'b1;
            WEN_T       <= 1'b1;
            A_T         <= '0;
            D_T         <= '0;
            r_pend      <= 1'b0;
            r_pend_addr <= '0;
            r_pend_exp  <= '0;
`ifdef BIST_CHECKERBOARD_EN
            r_pass      <= 1'b0;
`endif
        end else begin
            // D_T carries the expected background on read commands as well
            r_pend      <= r_busy & ~CSN_T & WEN_T;
            r_pend_addr <= A_T;
            r_pend_exp  <= D_T;
            if (r_pend && (Q_T != r_pend_exp)) begin
                fail_o <= 1'b1;
                if (fail_cnt_o != '1) fail_cnt_o <= fail_cnt_o + 1'b1;
                if (!fail_o) begin
                    fail_addr_o <= r_pend_addr;
                    fail_data_o <= Q_T;
                end
            end
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        r_state     <= S_M0;
                        r_busy      <= 1'b1;
                        done_o      <= 1'b0;
                        fail_o      <= 1'b0;
                        fail_cnt_o  <= '0;
                        fail_addr_o <= '0;
                        fail_data_o <= '0;
                        CSN_T       <= 1'b0;
                        WEN_T       <= 1'b0;
                        A_T         <= '0;
                        D_T         <= '0;
`ifdef BIST_CHECKERBOARD_EN
                        r_pass      <= 1'b0;
`endif
                    end
                end
                S_DRAIN: begin
                    r_state <= S_DONE;
                    r_busy  <= 1'b0;
                    done_o  <= 1'b1;
                end
                default: begin
                    r_state <= w_nstate;
                    A_T     <= w_naddr;
                    WEN_T   <= w_nwen;
                    CSN_T   <= ~w_ncmd;
                    D_T     <= w_ndata;
`ifdef BIST_CHECKERBOARD_EN
                    r_pass  <= w_npass;
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_register_file_bist_ctrl.sv
// Self-checking bench: march-table reference model plus a behavioural register file with injectable faults.
module tb_register_file_bist_ctrl;
    localparam int AW = 3;
    localparam int DW = 32;
    localparam int N  = 8;
`ifdef BIST_CHECKERBOARD_EN
    localparam int PASSES = 2;
`else
    localparam int PASSES = 1;
`endif
    localparam int OPS = 10 * N * PASSES;
    localparam logic [DW-1:0] Q2 = 32'h0000FFFF;

    logic clk = 1'b0, rst_n = 1'b0, start_i = 1'b0;
    logic busy_o, done_o, fail_o, BIST, CSN_T, WEN_T;
    logic [7:0] fail_cnt_o;
    logic [AW-1:0] fail_addr_o, A_T;
    logic [DW-1:0] fail_data_o, D_T, q_t;
    logic busy2, done2, fail2, bist2, csn2, wen2;
    logic [3:0] cnt2;
    logic [AW-1:0] faddr2, a2;
    logic [DW-1:0] fdata2, d2;

    always #5 clk = ~clk;

    register_file_bist_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
        .fail_o(fail_o), .fail_cnt_o(fail_cnt_o), .fail_addr_o(fail_addr_o), .fail_data_o(fail_data_o),
        .BIST(BIST), .CSN_T(CSN_T), .WEN_T(WEN_T), .A_T(A_T), .D_T(D_T), .Q_T(q_t));

    register_file_bist_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .busy_o(busy2), .done_o(done2),
        .fail_o(fail2), .fail_cnt_o(cnt2), .fail_addr_o(faddr2), .fail_data_o(fdata2),
        .BIST(bist2), .CSN_T(csn2), .WEN_T(wen2), .A_T(a2), .D_T(d2), .Q_T(Q2));

    // fault modes: 0 none, 1 read bit f_b of address f_a stuck at f_v, 2 writes to f_a also land in f_b
    int f_mode = 0, f_a = 0, f_b = 0;
    logic f_v = 1'b0;
    logic [DW-1:0] rf [N];

    function automatic logic [DW-1:0] rd_fault(input int a, input logic [DW-1:0] d);
        if (f_mode == 1 && a == f_a) d[f_b] = f_v;
        return d;
    endfunction

    initial q_t = '0;
    always @(posedge clk) begin
        if (BIST && !CSN_T) begin
            if (!WEN_T) begin
                rf[A_T] <= D_T;
                if (f_mode == 2 && int'(A_T) == f_a) rf[f_b] <= D_T;
            end else begin
                q_t <= rd_fault(int'(A_T), rf[A_T]);
            end
        end
    end

    typedef struct {bit wr; int a; logic [DW-1:0] d;} op_t;
    op_t ops[$];
    bit dn[6] = '{0, 0, 0, 1, 1, 1};
    bit rd[6] = '{0, 1, 1, 1, 1, 1};
    bit wr[6] = '{1, 1, 1, 1, 1, 0};
    bit rb[6] = '{0, 0, 1, 0, 1, 0};
    bit wb[6] = '{0, 1, 0, 1, 0, 0};

    function automatic logic [DW-1:0] bg(input int p, input bit one, input int a);
        logic [DW-1:0] base;
        base = (p == 0) ? 32'h0 : ((a % 2 == 1) ? 32'hAAAAAAAA : 32'h55555555);
        return one ? ~base : base;
    endfunction

    task automatic build_ops();
        ops.delete();
        for (int p = 0; p < PASSES; p++)
            for (int e = 0; e < 6; e++)
                for (int k = 0; k < N; k++) begin
                    int a;
                    a = dn[e] ? N - 1 - k : k;
                    if (rd[e]) ops.push_back('{1'b0, a, bg(p, rb[e], a)});
                    if (wr[e]) ops.push_back('{1'b1, a, bg(p, wb[e], a)});
                end
    endtask

    task automatic model(output bit ef, output int ec, output int ea, output logic [DW-1:0] ed);
        logic [DW-1:0] m [N];
        logic [DW-1:0] v;
        ef = 0; ec = 0; ea = 0; ed = '0;
        foreach (ops[i]) begin
            if (ops[i].wr) begin
                m[ops[i].a] = ops[i].d;
                if (f_mode == 2 && ops[i].a == f_a) m[f_b] = ops[i].d;
            end else begin
                v = rd_fault(ops[i].a, m[ops[i].a]);
                if (v !== ops[i].d) begin
                    if (!ef) begin ea = ops[i].a; ed = v; end
                    ef = 1;
                    if (ec < 255) ec++;
                end
            end
        end
    endtask

    int total = 0, bad = 0;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        int mode; int fa; int fb; bit fv; int pulse;
        int exp_fail; int exp_addr; int exp_cnt; bit chk_data; logic [DW-1:0] exp_data;
    } case_t;

    task automatic run_case(input string nm, input case_t tc);
        bit ef; int ec, ea; logic [DW-1:0] ed;
        int cmd_err, tim_err, first_c;
        bit cmd;
        f_mode = tc.mode; f_a = tc.fa; f_b = tc.fb; f_v = tc.fv;
        build_ops();
        model(ef, ec, ea, ed);
        cmd_err = 0; tim_err = 0; first_c = -1;
        @(negedge clk) start_i = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= OPS + 3; c++) begin
            @(negedge clk);
            start_i = (c == tc.pulse);
            cmd = (c <= OPS);
            if (CSN_T !== !cmd || BIST !== (c <= OPS + 1) || busy_o !== (c <= OPS + 1) ||
                done_o !== (c >= OPS + 2)) begin
                tim_err++;
                if (first_c < 0) first_c = c;
            end
            if (cmd && !CSN_T) begin
                if (WEN_T !== !ops[c-1].wr || int'(A_T) != ops[c-1].a ||
                    (ops[c-1].wr && D_T !== ops[c-1].d)) cmd_err++;
            end
        end
        start_i = 1'b0;
        chk($sformatf("%s cmd_seq_errors", nm), cmd_err, 0);
        chk($sformatf("%s timing_errors(first_cycle=%0d)", nm, first_c), tim_err, 0);
        chk($sformatf("%s fail_o", nm), fail_o, ef);
        chk($sformatf("%s fail_cnt_o", nm), fail_cnt_o, ec);
        if (ef) begin
            chk($sformatf("%s fail_addr_o", nm), fail_addr_o, ea);
            chk($sformatf("%s fail_data_o", nm), fail_data_o, ed);
        end
        if (tc.exp_fail >= 0) chk($sformatf("%s fail_o_tbl", nm), fail_o, tc.exp_fail);
        if (tc.exp_addr >= 0) chk($sformatf("%s fail_addr_tbl", nm), fail_addr_o, tc.exp_addr);
        if (tc.exp_cnt >= 0) chk($sformatf("%s fail_cnt_tbl", nm), fail_cnt_o, tc.exp_cnt);
        if (tc.chk_data) chk($sformatf("%s fail_data_tbl", nm), fail_data_o, tc.exp_data);
        chk($sformatf("%s sat_cnt", nm), cnt2, 15);
        chk($sformatf("%s sat_fail_addr", nm), faddr2, 0);
        chk($sformatf("%s sat_fail_data", nm), fdata2, Q2);
        chk($sformatf("%s sat_done_fail", nm), {done2, fail2, busy2}, 3'b110);
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, " status"}, {busy_o, done_o, fail_o, fail_cnt_o, fail_addr_o}, '0);
        chk({nm, " port"}, {BIST, CSN_T, WEN_T, A_T}, {1'b0, 1'b1, 1'b1, 3'd0});
        chk({nm, " fail_data"}, fail_data_o, '0);
        chk({nm, " D_T"}, D_T, '0);
        chk({nm, " sat_status"}, {busy2, done2, fail2, cnt2, faddr2}, '0);
    endtask

    case_t tbl[4];

    initial begin
        tbl[0] = '{0, 0, 0, 1'b0, 0,  0, -1, 0,          1'b0, '0};
        tbl[1] = '{1, 5, 0, 1'b0, 0,  1,  5, 2 * PASSES, 1'b1, 32'hFFFFFFFE};
        tbl[2] = '{2, 3, 2, 1'b0, 0,  1,  2, -1,         1'b0, '0};
        tbl[3] = '{0, 0, 0, 1'b0, 40, 0, -1, 0,          1'b0, '0};

        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset("idle");

        for (int i = 0; i < 4; i++) run_case($sformatf("tbl%0d", i), tbl[i]);

        for (int i = 0; i < 4; i++) begin
            case_t rc;
            rc.mode = $urandom_range(1, 2);
            rc.fa = $urandom_range(0, N - 1);
            if (rc.mode == 1) rc.fb = $urandom_range(0, DW - 1);
            else rc.fb = (rc.fa + $urandom_range(1, N - 1)) % N;
            rc.fv = 1'($urandom_range(0, 1));
            rc.pulse = $urandom_range(0, OPS);
            rc.exp_fail = -1; rc.exp_addr = -1; rc.exp_cnt = -1; rc.chk_data = 1'b0; rc.exp_data = '0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_case($sformatf("rnd%0d", i), rc);
        end

        // reset asserted in cycle 30 of a run
        f_mode = 0;
        @(negedge clk) start_i = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            start_i = 1'b0;
        end
        chk("pre_reset sat_fail", {fail2, busy2}, 2'b11);
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset("midrun_reset");
        rst_n = 1'b1;
        @(negedge clk);
        run_case("after_reset", tbl[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
